qos_arbiter: RTL and testbench
==============================

Name: qos_arbiter

Overview:
- Parametrised N-channel QoS arbiter for the PCIe QoS module; next generation of the 4-channel round-robin arbiter.
- Four run-time modes selected by `sel`:
  - plain round robin
  - arbitration-table driven
  - weighted round robin
  - weight-based strict priority
- Adds a request vector, a grant/ack handshake and generic channel count, table depth and weight width.
- Sits between the per-VC request queues and the link transmit mux.

Parameters:
- N_CH, 4, number of channels; power of two, 2..16.
- IDX_W, $clog2(N_CH), channel index width (derived).
- TBL_DEPTH, 16, arbitration table entries; power of two.
- W_BITS, 2, per-channel weight width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- enb  in  1  arbiter enable.
- sel  in  2  mode: 0 RR, 1 TABLE, 2 WRR, 3 PRIO.
- req  in  N_CH  per-channel request.
- ack  in  1  current grant consumed this cycle.
- table  in  TBL_DEPTH*IDX_W  entry k = table[k*IDX_W +: IDX_W].
- weight  in  N_CH*W_BITS  weight of ch c = weight[c*W_BITS +: W_BITS].
- grant  out  N_CH  one-hot grant, registered.
- grant_idx  out  IDX_W  binary index of the granted channel; 0 when no grant.
- grant_vld  out  1  grant is valid.

Behaviour:
- Reset state, asynchronous: grant=0, grant_idx=0, grant_vld=0, rr_ptr=N_CH-1, tbl_ptr=0, credit=0, sel_q=0.
- Outputs are registered. A new arbitration result appears on the clk edge after the inputs are sampled (latency 1).
- Arbitration runs on a cycle when all of the following hold:
  - enb=1;
  - grant_vld=0, OR ack=1, OR req[grant_idx]=0 (requester withdrew).
- Otherwise the grant is held stable.
- Requesters keep req high until ack. A withdrawn request loses its grant on the next cycle.
- If arbitration finds no eligible requester: grant=0, grant_vld=0, pointers unchanged.
- enb=0: grant/grant_vld clear on the next edge; rr_ptr, tbl_ptr and credit freeze.
- Mode change (sel != sel_q while enb=1): tbl_ptr=0 and credit=0 on that edge; rr_ptr is kept. The new mode arbitrates immediately.
- RR mode:
  - Pick the first requesting channel scanning upward from rr_ptr+1, mod N_CH.
  - rr_ptr takes the granted index.
- TABLE mode:
  - Scan entries tbl_ptr, tbl_ptr+1, ... (mod TBL_DEPTH); take the first entry k whose channel has req set.
  - Grant that channel; tbl_ptr=(k+1) mod TBL_DEPTH.
  - Duplicate entries are legal.
- WRR mode:
  - Current channel (rr_ptr) receives up to weight+1 consecutive grants, counted by credit.
  - Each acked grant increments credit. When credit reaches weight[rr_ptr], or the channel drops req, advance RR to the next requester and set credit=0.
  - A weight change takes effect on the next credit compare.
- PRIO mode:
  - Grant the requesting channel with the largest weight; ties go to the lowest index.
  - Non-preemptive: a held grant is not taken back until ack or withdrawal.
- Simultaneous ack and mode change: the new mode decides the next grant.
- Reset asserted mid-grant clears everything asynchronously. The first post-reset RR grant goes to ch0 when all channels request.
- grant is always one-hot or zero, and always matches grant_idx.

Decomposition:
- Package qos_arb_pkg:
  - mode constants MODE_RR=2'd0, MODE_TBL=2'd1, MODE_WRR=2'd2, MODE_PRIO=2'd3;
  - the index-to-one-hot function.
- Sub-module qos_rr_pick: combinational rotating priority encoder.
  - Inputs: vector, start index. Outputs: found, index.
  - Instantiated once for N_CH wide (RR/WRR) and once for TBL_DEPTH wide, over the table entries masked by req (TABLE).

Test Plan:
1. RR: N_CH=4, enb=1, sel=0, req=4'hF, ack=1 every cycle after reset -> grant sequence 0001, 0010, 0100, 1000, 0001; first grant one cycle after enb rises.
2. TABLE: table=32'hB19E6F92, sel=1, ack=1 each cycle.
   - req=4'hF -> grant_idx 2,0,1,2,3,3,2,1.
   - Then reset and req=4'b1011 -> 0,1,3,3,1 (ch2 entries skipped).
3. WRR: sel=2, weights ch0..ch3 = 1,3,2,0, req=4'hF, ack=1 -> ch0 x2, ch1 x4, ch2 x3, ch3 x1, then repeats.
   - Drop req[1] after its 2nd grant -> ch2 is granted the next cycle.
4. PRIO/handshake:
   - sel=3, weights 1,3,3,0, req=4'hF -> ch1.
   - Hold ack=0 for 5 cycles -> grant stays 0010.
   - req=4'b1101 -> ch2.
   - ack=0 with req[grant_idx] dropped -> grant re-arbitrated next cycle.
5. Control:
   - enb=0 mid-stream -> grant=0 next edge; enb=1 -> RR resumes after the last granted channel.
   - sel change 2->1 mid-credit -> credit=0, tbl_ptr=0.
   - Async reset mid-grant -> outputs 0 immediately, without a clock edge.
   - req=0 -> grant_vld=0.

Source files
------------

// File: rtl/qos_arb_pkg.sv
// Shared constants and helpers for the QoS arbiter: mode encodings and the
// index-to-one-hot conversion used to build the registered grant vector.
package qos_arb_pkg;

  localparam logic [1:0] MODE_RR   = 2'd0;
  localparam logic [1:0] MODE_TBL  = 2'd1;
  localparam logic [1:0] MODE_WRR  = 2'd2;
  localparam logic [1:0] MODE_PRIO = 2'd3;

  localparam int MAX_CH    = 16;
  localparam int MAX_IDX_W = 4;

  function automatic logic [MAX_CH-1:0] idx_to_onehot(input logic [MAX_IDX_W-1:0] idx);
    logic [MAX_CH-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/qos_rr_pick.sv
// Rotating priority encoder: finds the first set bit of vec scanning upward
// from start (inclusive), wrapping modulo W. W must be a power of two.
module qos_rr_pick #(
  parameter int W  = 4,
  parameter int IW = $clog2(W)
) (
  input  logic [W-1:0]  vec,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] pos;

  // NOTE: every variable written here gets a default first, so no path
  // through the block can leave it unassigned and infer a latch.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int i = 0; i < W; i++) begin
      pos = start + IW'(i);
      if (!found && vec[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/qos_arbiter.sv
// N-channel QoS arbiter with run-time selectable RR, table, weighted RR and
// weight-priority modes, a grant/ack handshake and registered one-hot grant.
module qos_arbiter
  import qos_arb_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int IDX_W     = $clog2(N_CH),
  parameter int TBL_DEPTH = 16,
  parameter int W_BITS    = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enb,
  input  logic [1:0]                 sel,
  input  logic [N_CH-1:0]            req,
  input  logic                       ack,
  // "table" is a reserved word, hence the prefix.
  input  logic [TBL_DEPTH*IDX_W-1:0] arb_table,
  input  logic [N_CH*W_BITS-1:0]     weight,
  output logic [N_CH-1:0]            grant,
  output logic [IDX_W-1:0]           grant_idx,
  output logic                       grant_vld
);

  localparam int TBL_W = $clog2(TBL_DEPTH);

  logic [IDX_W-1:0]  rr_ptr;
  logic [TBL_W-1:0]  tbl_ptr;
  logic [W_BITS-1:0] credit;
  logic [1:0]        sel_q;

  logic              mode_change;
  logic              arb_en;
  logic [IDX_W-1:0]  rr_start;
  logic [W_BITS-1:0] cur_wgt;
  logic              wrr_stay;

  logic              rr_found;
  logic [IDX_W-1:0]  rr_idx;

  logic [TBL_DEPTH-1:0] tbl_vec;
  logic [TBL_W-1:0]     tbl_start;
  logic                 tbl_found;
  logic [TBL_W-1:0]     tbl_hit;
  logic [IDX_W-1:0]     tbl_ch;

  logic              prio_found;
  logic [IDX_W-1:0]  prio_idx;
  logic [W_BITS-1:0] prio_w;

  logic              nxt_vld;
  logic [IDX_W-1:0]  nxt_idx;
  logic [N_CH-1:0]   nxt_grant;
  logic [IDX_W-1:0]  nxt_rr;
  logic [TBL_W-1:0]  nxt_tbl;
  logic [W_BITS-1:0] nxt_credit;
  logic [MAX_IDX_W-1:0] idx_ext;
  logic [MAX_CH-1:0]    idx_oh;

  assign mode_change = (sel != sel_q);
  assign arb_en      = enb && (!grant_vld || ack || !req[grant_idx]);
  assign rr_start    = rr_ptr + 1'b1;
  assign cur_wgt     = weight[rr_ptr*W_BITS +: W_BITS];
  assign tbl_start   = mode_change ? '0 : tbl_ptr;
  assign tbl_ch      = arb_table[tbl_hit*IDX_W +: IDX_W];

  // The current WRR channel keeps the grant while it has credit left.
  assign wrr_stay = grant_vld && !mode_change && ack && req[rr_ptr] &&
                    (credit < cur_wgt);

  always_comb begin
    tbl_vec = '0;
    for (int k = 0; k < TBL_DEPTH; k++) begin
      tbl_vec[k] = req[arb_table[k*IDX_W +: IDX_W]];
    end
  end

  qos_rr_pick #(.W(N_CH), .IW(IDX_W)) u_rr_pick (
    .vec   (req),
    .start (rr_start),
    .found (rr_found),
    .idx   (rr_idx)
  );

  qos_rr_pick #(.W(TBL_DEPTH), .IW(TBL_W)) u_tbl_pick (
    .vec   (tbl_vec),
    .start (tbl_start),
    .found (tbl_found),
    .idx   (tbl_hit)
  );

  // Strict '>' keeps the lowest index on equal weights.
  always_comb begin
    prio_found = 1'b0;
    prio_idx   = '0;
    prio_w     = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (req[c] && (!prio_found || weight[c*W_BITS +: W_BITS] > prio_w)) begin
        prio_found = 1'b1;
        prio_idx   = IDX_W'(c);
        prio_w     = weight[c*W_BITS +: W_BITS];
      end
    end
  end

  always_comb begin
    nxt_vld    = grant_vld;
    nxt_idx    = grant_idx;
    nxt_rr     = rr_ptr;
    nxt_tbl    = tbl_ptr;
    nxt_credit = credit;
    if (!enb) begin
      nxt_vld = 1'b0;
      nxt_idx = '0;
    end else begin
      if (mode_change) begin
        nxt_tbl    = '0;
        nxt_credit = '0;
      end
      if (arb_en) begin
        nxt_vld = 1'b0;
        nxt_idx = '0;
        case (sel)
          MODE_RR: begin
            if (rr_found) begin
              nxt_vld = 1'b1;
              nxt_idx = rr_idx;
              nxt_rr  = rr_idx;
            end
          end
          MODE_TBL: begin
            if (tbl_found) begin
              nxt_vld = 1'b1;
              nxt_idx = tbl_ch;
              nxt_tbl = tbl_hit + 1'b1;
            end
          end
          MODE_WRR: begin
            if (wrr_stay) begin
              nxt_vld    = 1'b1;
              nxt_idx    = rr_ptr;
              nxt_credit = credit + 1'b1;
            end else if (rr_found) begin
              nxt_vld    = 1'b1;
              nxt_idx    = rr_idx;
              nxt_rr     = rr_idx;
              nxt_credit = '0;
            end
          end
          default: begin
            if (prio_found) begin
              nxt_vld = 1'b1;
              nxt_idx = prio_idx;
            end
          end
        endcase
      end
    end

    idx_ext              = '0;
    idx_ext[IDX_W-1:0]   = nxt_idx;
    idx_oh               = idx_to_onehot(idx_ext);
    nxt_grant            = nxt_vld ? idx_oh[N_CH-1:0] : '0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, matching real hardware.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant     <= '0;
      grant_idx <= '0;
      grant_vld <= 1'b0;
      rr_ptr    <= IDX_W'(N_CH - 1);
      tbl_ptr   <= '0;
      credit    <= '0;
      sel_q     <= MODE_RR;
    end else begin
      grant     <= nxt_grant;
      grant_idx <= nxt_idx;
      grant_vld <= nxt_vld;
      rr_ptr    <= nxt_rr;
      tbl_ptr   <= nxt_tbl;
      credit    <= nxt_credit;
      if (enb) sel_q <= sel;
    end
  end

endmodule

// File: tb/tb_qos_arbiter.sv
// Directed, table-driven bench for qos_arbiter (4 channels, 16-entry table,
// 2-bit weights) plus a hand-written asynchronous reset sequence.
module tb_qos_arbiter;

  localparam logic [31:0] TBL_CFG = 32'hB19E6F92;
  localparam logic [7:0]  W_WRR   = 8'h2D;  // ch0..ch3 = 1,3,2,0
  localparam logic [7:0]  W_PRIO  = 8'h3D;  // ch0..ch3 = 1,3,3,0
  localparam logic [7:0]  W_TIE   = 8'hAA;  // all 2

  logic        clk = 1'b0;
  logic        reset;
  logic        enb;
  logic [1:0]  sel;
  logic [3:0]  req;
  logic        ack;
  logic [31:0] arb_table;
  logic [7:0]  weight;
  logic [3:0]  grant;
  logic [1:0]  grant_idx;
  logic        grant_vld;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         rst;
    bit         enb;
    logic [1:0] sel;
    logic [3:0] req;
    bit         ack;
    logic [7:0] wgt;
    bit         exp_vld;
    logic [1:0] exp_idx;
  } vec_t;

  vec_t vecs[$];

  qos_arbiter #(.N_CH(4), .TBL_DEPTH(16), .W_BITS(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .enb       (enb),
    .sel       (sel),
    .req       (req),
    .ack       (ack),
    .arb_table (arb_table),
    .weight    (weight),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input bit vld, input logic [1:0] idx);
    logic [3:0] exp_grant;
    exp_grant = vld ? (4'b0001 << idx) : 4'b0000;
    check({tag, "_grant"}, 32'(grant), 32'(exp_grant));
    check({tag, "_idx"},   32'(grant_idx), vld ? 32'(idx) : 32'd0);
    check({tag, "_vld"},   32'(grant_vld), 32'(vld));
  endtask

  task automatic add(input bit r, input bit e, input logic [1:0] s, input logic [3:0] q,
                     input bit a, input logic [7:0] w, input bit v, input logic [1:0] i);
    vecs.push_back('{r, e, s, q, a, w, v, i});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    enb   = 1'b0;
    ack   = 1'b0;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    enb       = 1'b0;
    sel       = 2'd0;
    req       = 4'h0;
    ack       = 1'b0;
    arb_table = TBL_CFG;
    weight    = W_WRR;

    // RR: first grant one edge after enb, rotation, enb drop and resume, idle
    add(1, 0, 0, 4'hF, 0, W_WRR, 0, 0);
    add(0, 1, 0, 4'hF, 1, W_WRR, 1, 0);
    add(0, 1, 0, 4'hF, 1, W_WRR, 1, 1);
    add(0, 1, 0, 4'hF, 1, W_WRR, 1, 2);
    add(0, 1, 0, 4'hF, 1, W_WRR, 1, 3);
    add(0, 1, 0, 4'hF, 1, W_WRR, 1, 0);
    add(0, 1, 0, 4'hF, 1, W_WRR, 1, 1);
    add(0, 0, 0, 4'hF, 1, W_WRR, 0, 0);
    add(0, 1, 0, 4'hF, 1, W_WRR, 1, 2);
    add(0, 1, 0, 4'h0, 1, W_WRR, 0, 0);
    add(0, 1, 0, 4'hF, 1, W_WRR, 1, 3);

    // TABLE with all requesting, WRR detour, table restarts at entry 0
    add(1, 1, 1, 4'hF, 1, W_WRR, 1, 2);
    add(0, 1, 1, 4'hF, 1, W_WRR, 1, 0);
    add(0, 1, 1, 4'hF, 1, W_WRR, 1, 1);
    add(0, 1, 1, 4'hF, 1, W_WRR, 1, 2);
    add(0, 1, 1, 4'hF, 1, W_WRR, 1, 3);
    add(0, 1, 1, 4'hF, 1, W_WRR, 1, 3);
    add(0, 1, 1, 4'hF, 1, W_WRR, 1, 2);
    add(0, 1, 1, 4'hF, 1, W_WRR, 1, 1);
    add(0, 1, 2, 4'hF, 1, W_WRR, 1, 0);
    add(0, 1, 1, 4'hF, 1, W_WRR, 1, 2);
    add(0, 1, 1, 4'hF, 1, W_WRR, 1, 0);
    add(0, 1, 1, 4'hF, 1, W_WRR, 1, 1);
    // TABLE skipping ch2 entries
    add(1, 1, 1, 4'hB, 1, W_WRR, 1, 0);
    add(0, 1, 1, 4'hB, 1, W_WRR, 1, 1);
    add(0, 1, 1, 4'hB, 1, W_WRR, 1, 3);
    add(0, 1, 1, 4'hB, 1, W_WRR, 1, 3);
    add(0, 1, 1, 4'hB, 1, W_WRR, 1, 1);

    // WRR: 2,4,3,1 grants per channel, then a withdrawal and mode hops
    add(1, 1, 2, 4'hF, 1, W_WRR, 1, 0);
    add(0, 1, 2, 4'hF, 1, W_WRR, 1, 0);
    add(0, 1, 2, 4'hF, 1, W_WRR, 1, 1);
    add(0, 1, 2, 4'hF, 1, W_WRR, 1, 1);
    add(0, 1, 2, 4'hF, 1, W_WRR, 1, 1);
    add(0, 1, 2, 4'hF, 1, W_WRR, 1, 1);
    add(0, 1, 2, 4'hF, 1, W_WRR, 1, 2);
    add(0, 1, 2, 4'hF, 1, W_WRR, 1, 2);
    add(0, 1, 2, 4'hF, 1, W_WRR, 1, 2);
    add(0, 1, 2, 4'hF, 1, W_WRR, 1, 3);
    add(0, 1, 2, 4'hF, 1, W_WRR, 1, 0);
    add(0, 1, 2, 4'hF, 1, W_WRR, 1, 0);
    add(0, 1, 2, 4'hF, 1, W_WRR, 1, 1);
    add(0, 1, 2, 4'hF, 1, W_WRR, 1, 1);
    add(0, 1, 2, 4'hD, 1, W_WRR, 1, 2);
    add(0, 1, 2, 4'hD, 1, W_WRR, 1, 2);
    add(0, 1, 1, 4'hF, 1, W_WRR, 1, 2);
    add(0, 1, 1, 4'hF, 1, W_WRR, 1, 0);
    add(0, 1, 2, 4'hF, 1, W_WRR, 1, 3);
    add(0, 1, 2, 4'hF, 1, W_WRR, 1, 0);
    add(0, 1, 2, 4'hF, 1, W_WRR, 1, 0);
    add(0, 1, 2, 4'hF, 1, W_WRR, 1, 1);

    // PRIO: non-preemptive hold, withdrawals, idle, tie to lowest index
    add(1, 1, 3, 4'hF, 0, W_PRIO, 1, 1);
    for (int k = 0; k < 5; k++) add(0, 1, 3, 4'hF, 0, W_PRIO, 1, 1);
    add(0, 1, 3, 4'hD, 0, W_PRIO, 1, 2);
    add(0, 1, 3, 4'h9, 0, W_PRIO, 1, 0);
    add(0, 1, 3, 4'h9, 1, W_PRIO, 1, 0);
    add(0, 1, 3, 4'h0, 0, W_PRIO, 0, 0);
    add(0, 1, 3, 4'hE, 1, W_TIE,  1, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) do_reset();
      enb    = vecs[i].enb;
      sel    = vecs[i].sel;
      req    = vecs[i].req;
      ack    = vecs[i].ack;
      weight = vecs[i].wgt;
      step();
      check_out($sformatf("v%0d", i), vecs[i].exp_vld, vecs[i].exp_idx);
    end

    // Asynchronous reset in the middle of a grant, no clock edge involved
    do_reset();
    enb    = 1'b1;
    sel    = 2'd0;
    req    = 4'hF;
    ack    = 1'b1;
    weight = W_WRR;
    step();
    check_out("ar_pre0", 1'b1, 2'd0);
    step();
    check_out("ar_pre1", 1'b1, 2'd1);
    #2 reset = 1'b1;
    #1 check_out("ar_async", 1'b0, 2'd0);
    #2 reset = 1'b0;
    step();
    check_out("ar_post", 1'b1, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
